// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and op legality.
// Imported by alu_seq and alu_seq_comb.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_INC  = 4'd6,
        OP_ASR1 = 4'd7,
        OP_ASRN = 4'd8,
        OP_MUL  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_legal(op_e op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Combinational WIDTH-bit datapath for the single-cycle ops (0..7).
// Zero latency; no handshake, carry is meaningful only for ADD/SUB/INC.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        sum    = '0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                // carry out set means no borrow
                sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~b;
            OP_INC: begin
                sum    = {1'b0, b} + (WIDTH+1)'(1);
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_ASR1: result = {b[WIDTH-1], b[WIDTH-1:1]};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops, iterative ASRN and shift-add MUL.
// Latency 1 (single-cycle / ASRN 0), k+1 (ASRN k), WIDTH+1 (MUL); outputs held while out_ready=0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] e,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    state_e           state, nxt_state;
    logic [CW-1:0]    count;
    logic             busy_mul;
    logic [WIDTH-1:0] acc, mpl, mcand;

    op_e              op_in;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] comb_res;
    logic             comb_carry;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] acc_nxt, mpl_mul_nxt, asr_nxt;

    logic             load;
    logic [WIDTH-1:0] fin_res;
    logic             fin_v, fin_err;

    assign op_in     = op_e'(op);
    assign shamt     = a[SHW-1:0];
    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .a      (a),
        .b      (b),
        .op     (op_in),
        .result (comb_res),
        .carry  (comb_carry)
    );

    // mpl doubles as the ASRN shift register and the MUL multiplier / low product half
    assign mul_sum     = {1'b0, acc} + {1'b0, (mpl[0] ? mcand : {WIDTH{1'b0}})};
    assign acc_nxt     = mul_sum[WIDTH:1];
    assign mpl_mul_nxt = {mul_sum[0], mpl[WIDTH-1:1]};
    assign asr_nxt     = {mpl[WIDTH-1], mpl[WIDTH-1:1]};

    always_comb begin
        nxt_state = state;
        load      = 1'b0;
        fin_res   = '0;
        fin_v     = 1'b0;
        fin_err   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (op_in == OP_MUL) begin
                        nxt_state = BUSY;
                    end else if ((op_in == OP_ASRN) && (shamt != '0)) begin
                        nxt_state = BUSY;
                    end else begin
                        nxt_state = DONE;
                        load      = 1'b1;
                        if (!is_legal(op_in)) begin
                            fin_err = 1'b1;
                        end else if (op_in == OP_ASRN) begin
                            fin_res = b;
                        end else begin
                            fin_res = comb_res;
                            fin_v   = comb_carry;
                        end
                    end
                end else if (state == DONE && out_ready) begin
                    nxt_state = IDLE;
                end
            end
            BUSY: begin
                if (count == CW'(1)) begin
                    nxt_state = DONE;
                    load      = 1'b1;
                    if (busy_mul) begin
                        fin_res = mpl_mul_nxt;
                        fin_v   = |acc_nxt;
                    end else begin
                        fin_res = asr_nxt;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            busy_mul <= 1'b0;
            acc      <= '0;
            mpl      <= '0;
            mcand    <= '0;
            e        <= '0;
            z        <= 1'b0;
            v        <= 1'b0;
            n        <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= nxt_state;
            if (accept) begin
                busy_mul <= (op_in == OP_MUL);
                acc      <= '0;
                mcand    <= a;
                mpl      <= b;
                count    <= (op_in == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
            end else if (state == BUSY) begin
                count <= count - CW'(1);
                if (busy_mul) begin
                    acc <= acc_nxt;
                    mpl <= mpl_mul_nxt;
                end else begin
                    mpl <= asr_nxt;
                end
            end
            if (load) begin
                e   <= fin_res;
                z   <= (fin_res == '0);
                v   <= fin_v;
                n   <= fin_res[WIDTH-1];
                err <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=4: directed cases, throughput, backpressure, reset mid-op,
// and randomized ops against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         in_ready, out_valid, z, v, n, err;
    logic [W-1:0] e;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .e         (e),
        .z         (z),
        .v         (v),
        .n         (n),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the op definitions
    task automatic model(input int opc, input int ia, input int ib,
                         output int re, output int rv, output int rerr, output int rlat);
        int sb, k, s;
        re = 0; rv = 0; rerr = 0; rlat = 1; s = 0;
        sb = (ib >= M/2) ? ib - M : ib;
        case (opc)
            0: begin s = ia + ib;                re = s % M; rv = s / M; end
            1: begin s = ia + (M - 1 - ib) + 1; re = s % M; rv = s / M; end
            2: re = ia & ib;
            3: re = ia | ib;
            4: re = ia ^ ib;
            5: re = M - 1 - ib;
            6: begin s = ib + 1; re = s % M; rv = s / M; end
            7: re = (sb >>> 1) & (M - 1);
            8: begin k = ia % W; re = (sb >>> k) & (M - 1); rlat = k + 1; end
            9: begin s = ia * ib; re = s % M; rv = (s >= M) ? 1 : 0; rlat = W + 1; end
            default: rerr = 1;
        endcase
    endtask

    task automatic check_res(input string tag, input int ee, input int ev, input int eerr);
        check({tag, "_e"},   32'(e),   ee);
        check({tag, "_z"},   32'(z),   (ee == 0) ? 1 : 0);
        check({tag, "_n"},   32'(n),   (ee >= M/2) ? 1 : 0);
        check({tag, "_v"},   32'(v),   ev);
        check({tag, "_err"}, 32'(err), eerr);
    endtask

    // One beat: accept, measure latency, check result, optionally stall then consume.
    task automatic send(input int opc, input int ia, input int ib, input int stall, input bit release_it);
        int ee, ev, eerr, elat, lat;
        model(opc, ia, ib, ee, ev, eerr, elat);
        @(negedge clk);
        in_valid  = 1'b1;
        op = 4'(opc); a = 4'(ia); b = 4'(ib);
        out_ready = 1'b0;
        check("acc_rdy", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            check("busy_rdy", 32'(in_ready), 0);
            lat++;
            @(negedge clk);
        end
        check("lat", 32'(lat), elat);
        check_res("res", ee, ev, eerr);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_vld", 32'(out_valid), 1);
            check("hold_rdy", 32'(in_ready), 0);
            check("hold_e", 32'(e), ee);
        end
        if (release_it) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    int dop[8] = '{0, 1, 9, 9, 8, 8, 15, 5};
    int da[8]  = '{5, 5, 3, 5, 2, 0, 0, 0};
    int db[8]  = '{13, 13, 5, 13, 8, 8, 0, 0};
    int tpo[6] = '{0, 2, 4, 6, 15, 1};
    int tpa[6], tpb[6];

    initial begin
        int ee, ev, eerr, el;
        bit seen;

        #2 rst_n = 1'b0;
        #1;
        check("rst_vld", 32'(out_valid), 0);
        check("rst_rdy", 32'(in_ready), 1);
        check("rst_e", 32'(e), 0);
        check("rst_flags", 32'({z, v, n, err}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            send(dop[i], da[i], db[i], (i == 0) ? 2 : 0, 1'b1);

        // backpressure, then next beat accepted on the releasing edge
        send(0, 1, 1, 5, 1'b0);
        in_valid = 1'b1; op = 4'd4; a = 4'hf; b = 4'hf; out_ready = 1'b1;
        #1;
        check("bp_rdy", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_vld", 32'(out_valid), 1);
        check_res("bp", 0, 0, 0);
        @(posedge clk);
        #1 out_ready = 1'b0;

        // back-to-back throughput with out_ready held high
        for (int i = 0; i < 6; i++) begin
            tpa[i] = $urandom_range(0, 15);
            tpb[i] = $urandom_range(0, 15);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        op = 4'(tpo[0]); a = 4'(tpa[0]); b = 4'(tpb[0]);
        for (int i = 0; i < 6; i++) begin
            check("tp_rdy", 32'(in_ready), 1);
            @(posedge clk);
            #1;
            if (i < 5) begin
                op = 4'(tpo[i+1]); a = 4'(tpa[i+1]); b = 4'(tpb[i+1]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            model(tpo[i], tpa[i], tpb[i], ee, ev, eerr, el);
            check("tp_vld", 32'(out_valid), 1);
            check_res("tp", ee, ev, eerr);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;

        for (int i = 0; i < 150; i++)
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 2), 1'b1);

        // reset in the middle of a multiply; e is 1111 beforehand
        send(5, 0, 0, 0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; op = 4'd9; a = 4'd5; b = 4'd13;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mr_vld", 32'(out_valid), 0);
        check("mr_e", 32'(e), 0);
        check("mr_flags", 32'({z, v, n, err}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_rdy", 32'(in_ready), 1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("mr_stale", 32'(seen), 0);
        send(0, 3, 4, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked sequential ALU: the next generation of the team's 4-bit combinational ALU, generalised to WIDTH bits. It keeps the eight original single-cycle operations and adds multi-cycle variable arithmetic shift right and shift-add multiply. Operands are accepted through a valid/ready input port, and results are returned through a registered valid/ready output port with flags. It sits between the operand register file and the writeback stage of the datapath.

## Interface
- WIDTH, 8: operand and result width; legal range 2..32.
- SHW, $clog2(WIDTH): shift-amount field width. Derived; not overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts an operand beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  operation code (see Operation).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- e  out  WIDTH  result.
- z  out  1  result is zero.
- v  out  1  carry or overflow (per op).
- n  out  1  e[WIDTH-1].
- err  out  1  op code was illegal.

## Operation
- Op codes:
  - 0 ADD: a+b.
  - 1 SUB: a+~b+1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~b.
  - 6 INC: b+1.
  - 7 ASR1: b>>>1.
  - 8 ASRN: b>>>a[SHW-1:0].
  - 9 MUL: low WIDTH bits of a*b, unsigned.
  - 10..15 illegal.
- v rules:
  - ADD, SUB, INC: carry out of bit WIDTH-1. For SUB, v=1 means no borrow.
  - MUL: v=1 if any bit of the upper product half is nonzero.
  - All other ops: v=0.
- z = (e==0). n = e[WIDTH-1]. Both are computed from the final result.
- Illegal op: e=0, z=1, v=0, n=0, err=1. It completes as a single-cycle op. err=0 for all legal ops.
- FSM states are IDLE, BUSY, DONE.
- Transitions:
  - IDLE, in_valid & in_ready:
    - Single-cycle op, or ASRN with shift 0: go to DONE with the result registered.
    - ASRN with shift k>0: go to BUSY with count=k, shift register=b.
    - MUL: go to BUSY with count=WIDTH, accumulator=0, multiplicand=a, multiplier=b.
  - BUSY, each cycle: ASRN shifts one bit arithmetically; MUL performs one shift-add step. count decrements. When count reaches 1, registers the result and flags and goes to DONE.
  - DONE, out_valid=1. On out_ready:
    - If in_valid is also high, accept the new beat; next state as from IDLE.
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready=0 throughout BUSY.
- Reset (asserted at any time, including mid-BUSY): state=IDLE, out_valid=0, e=0, z=0, v=0, n=0, err=0. Any in-flight operation is discarded and never emitted.

## Timing
- Acceptance edge t is the edge where in_valid & in_ready.
- Single-cycle ops and ASRN with shift 0: out_valid at t+1.
- ASRN with shift k>0: out_valid at t+k+1.
- MUL: out_valid at t+WIDTH+1.
- With out_ready held high, back-to-back single-cycle ops sustain one result per cycle.
- While out_valid=1 and out_ready=0: e, z, v, n, err are held stable, and no new beat is accepted.
- a, b, op are sampled only at the acceptance edge. Later changes on these inputs have no effect on the operation in flight.
- All outputs are registered except in_ready, which is combinational from state and out_ready.

## Structure
- Package alu_seq_pkg holds:
  - op_e enum (4-bit, values above).
  - state_e enum {IDLE, BUSY, DONE}.
  - Function is_legal(op_e).
- Sub-module alu_seq_comb: purely combinational WIDTH-bit datapath for ops 0..7. Outputs result and carry.
- Top level holds the FSM, count register, shift/multiply registers, output registers and flag generation.

## Test plan
- WIDTH=4. Each of the following is accepted at t with out_ready=1:
  - ADD a=0101 b=1101 -> at t+1: e=0010 v=1 z=0 n=0.
  - SUB a=0101 b=1101 -> at t+1: e=1000 v=0 n=1.
  - MUL a=0011 b=0101 -> out_valid first at t+5: e=1111 v=0; in_ready=0 from t+1 to t+4.
  - MUL a=0101 b=1101 -> at t+5: e=0001 v=1.
- ASRN b=1000 a=0010 -> out_valid at t+3, e=1110 n=1. Repeat with a=0000 -> out_valid at t+1, e=1000.
- Backpressure: ADD 0001+0001, then hold out_ready=0 for 5 cycles. Required: e=0010 stable with out_valid=1 and in_ready=0 throughout. Then assert out_ready with the next beat (XOR 1111,1111) valid: accepted on that edge, and e=0000 z=1 on the following cycle.
- Illegal op 1111 -> at t+1: e=0000 z=1 err=1 v=0. Next legal op (op=5, NOT b=0000) -> e=1111 err=0.
- Reset mid-MUL: deassert rst_n at t+2 for one cycle. Required: out_valid=0 and all outputs 0 immediately (asynchronous); in_ready=1 after release; no stale result ever emitted.
